alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 The module SHALL expose parameter WIDTH, default 32, meaning the data operand and result width in bits (legal range 8..64).
REQ-002 The module SHALL be clocked by a single clock and SHALL use a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all registers.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 aluOp  input  4  ALU control code selecting the operation.
REQ-006 data1  input  WIDTH  first operand (A).
REQ-007 data2  input  WIDTH  second operand (B).
REQ-008 in_valid  input  1  operands and aluOp are sampled on this cycle.
REQ-009 result  output  WIDTH  registered operation result.
REQ-010 zero  output  1  registered flag: result equals 0.
REQ-011 overflow  output  1  registered two's-complement overflow flag for ADD/SUB.
REQ-012 out_valid  output  1  result/zero/overflow hold a new value this cycle.

Function
REQ-013 aluOp 0000 SHALL produce A AND B, bitwise.
REQ-014 aluOp 0001 SHALL produce A OR B, bitwise.
REQ-015 aluOp 0010 SHALL produce A + B modulo 2^WIDTH.
REQ-016 aluOp 0110 SHALL produce A - B modulo 2^WIDTH.
REQ-017 aluOp 0111 (SLT) SHALL produce 1 when A < B as signed two's-complement values, else 0, zero-extended to WIDTH.
REQ-018 aluOp 1100 SHALL produce NOT (A OR B), bitwise.
REQ-019 Every other aluOp code SHALL produce result 0 and overflow 0.
REQ-020 overflow SHALL be 1 for ADD only when A and B have equal sign bits and the sum's sign differs from them.
REQ-021 overflow SHALL be 1 for SUB only when A and B have differing sign bits and the difference's sign differs from A.
REQ-022 overflow SHALL be 0 for all operations other than ADD and SUB.
REQ-023 SLT SHALL be correct when the subtraction overflows: compare true signed values, not the sign of A-B alone.
REQ-024 zero SHALL be 1 when the computed result is all zeros, for every operation, including undefined codes.
REQ-025 Latency SHALL be exactly 1 cycle: inputs sampled on edge N with in_valid=1 appear on result/zero/overflow with out_valid=1 after edge N.
REQ-026 With in_valid=0 at an edge, out_valid SHALL be 0 after that edge, and result/zero/overflow SHALL hold their previous values.
REQ-027 Back-to-back in_valid=1 cycles SHALL give one result per cycle with no bubbles; there is no backpressure.
REQ-028 Carry-out beyond WIDTH bits SHALL be discarded and SHALL NOT be reported.

Reset
REQ-029 While rst=1 at a rising edge, result SHALL become 0, zero SHALL become 1, overflow SHALL become 0 and out_valid SHALL become 0.
REQ-030 rst SHALL take priority over in_valid in the same cycle; an operation presented with rst=1 is discarded.
REQ-031 The first operation accepted after rst deasserts SHALL complete normally with 1-cycle latency.

Verification
REQ-032 Reset check: rst=1 for 2 cycles, then 0 -> result=0, zero=1, overflow=0, out_valid=0.
REQ-033 ADD/SUB: ADD A=0x00000005 B=0x00000003 -> result=0x00000008, zero=0. SUB A=B=0x12345678 -> result=0, zero=1, overflow=0.
REQ-034 Overflow: ADD 0x7FFFFFFF+0x00000001 -> 0x80000000, overflow=1. SUB 0x80000000-0x00000001 -> 0x7FFFFFFF, overflow=1. ADD 0xFFFFFFFF+0x00000001 -> 0, overflow=0, zero=1.
REQ-035 Logic and undefined codes: AND 0xF0F0F0F0,0xFF00FF00 -> 0xF000F000. OR -> 0xFFF0FFF0. NOR -> 0x000F000F. aluOp 0011 -> result 0, zero=1.
REQ-036 SLT: A=0xFFFFFFFF B=0x00000001 -> 1. A=0x80000000 B=0x7FFFFFFF -> 1. A=0x7FFFFFFF B=0x80000000 -> 0. A=B -> 0.
REQ-037 Streaming and hold: 3 consecutive valid ops -> 3 consecutive out_valid cycles with matching results. Then in_valid=0 -> out_valid=0, result held. Reset asserted mid-stream -> reset values on the next cycle.

Source files
------------

// File: rtl/alu.sv
// Single-cycle registered ALU: AND/OR/ADD/SUB/SLT/NOR with zero and signed-overflow flags.
// Results appear one clock after in_valid; with in_valid low the outputs hold and out_valid drops.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       aluOp,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic             in_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             out_valid
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    // Operands share a sign; the sum's sign flipped away from it.
    function automatic logic add_overflow(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    // Operands differ in sign; the difference's sign flipped away from A.
    function automatic logic sub_overflow(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic [WIDTH-1:0] d);
        return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
    endfunction

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic             less_s;
    logic [WIDTH-1:0] result_s;
    logic             overflow_s;
    logic             zero_s;

    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             overflow_r;
    logic             out_valid_r;

    assign sum_s  = data1 + data2;
    assign diff_s = data1 - data2;
    // A true signed compare keeps SLT correct even when A-B overflows.
    assign less_s = ($signed(data1) < $signed(data2));

    // Operation select and overflow flag.
    always_comb begin
        result_s   = {WIDTH{1'b0}};
        overflow_s = 1'b0;
        case (aluOp)
            OP_AND: result_s = data1 & data2;
            OP_OR:  result_s = data1 | data2;
            OP_ADD: begin
                result_s   = sum_s;
                overflow_s = add_overflow(data1, data2, sum_s);
            end
            OP_SUB: begin
                result_s   = diff_s;
                overflow_s = sub_overflow(data1, data2, diff_s);
            end
            OP_SLT: result_s = {{(WIDTH-1){1'b0}}, less_s};
            OP_NOR: result_s = ~(data1 | data2);
            default: begin
                result_s   = {WIDTH{1'b0}};
                overflow_s = 1'b0;
            end
        endcase
    end

    assign zero_s = (result_s == {WIDTH{1'b0}});

    // Output registers: reset wins, valid loads, otherwise hold data and drop valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r    <= {WIDTH{1'b0}};
            zero_r      <= 1'b1;
            overflow_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (in_valid) begin
            result_r    <= result_s;
            zero_r      <= zero_s;
            overflow_r  <= overflow_s;
            out_valid_r <= 1'b1;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign result    = result_r;
    assign zero      = zero_r;
    assign overflow  = overflow_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, streaming/hold/reset sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_alu;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic [3:0]       aluOp;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             in_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             out_valid;

    alu #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .aluOp(aluOp), .data1(data1), .data2(data2),
        .in_valid(in_valid), .result(result), .zero(zero),
        .overflow(overflow), .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected held output state
    logic [WIDTH-1:0] exp_res;
    logic             exp_z;
    logic             exp_ov;
    logic             exp_v;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic       z;
        logic       ov;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic check_outputs(input string name);
        check({name, ".result"},    {32'd0, result},    {32'd0, exp_res});
        check({name, ".zero"},      {63'd0, zero},      {63'd0, exp_z});
        check({name, ".overflow"},  {63'd0, overflow},  {63'd0, exp_ov});
        check({name, ".out_valid"}, {63'd0, out_valid}, {63'd0, exp_v});
    endtask

    // Reference: plain signed/unsigned arithmetic on wide integers.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic ov);
        longint sa, sb, t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 32'd0;
        ov = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                t  = sa + sb;
                r  = t[31:0];
                ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'b0110: begin
                t  = sa - sb;
                r  = t[31:0];
                ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b1100: r = ~(a | b);
            default: r = 32'd0;
        endcase
    endtask

    // Present one cycle of input and update the expected state.
    task automatic step(input logic r_in, input logic v_in, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mr;
        logic        mov;
        rst = r_in; in_valid = v_in; aluOp = op; data1 = a; data2 = b;
        @(posedge clk);
        #1;
        if (r_in) begin
            exp_res = 32'd0; exp_z = 1'b1; exp_ov = 1'b0; exp_v = 1'b0;
        end else if (v_in) begin
            model(op, a, b, mr, mov);
            exp_res = mr; exp_z = (mr == 32'd0); exp_ov = mov; exp_v = 1'b1;
        end else begin
            exp_v = 1'b0;
        end
    endtask

    initial begin
        logic [3:0] op_list[8];
        logic [3:0] rop;
        vecs[0]  = '{"add_5_3",     4'b0010, 32'h00000005, 32'h00000003, 32'h00000008, 1'b0, 1'b0};
        vecs[1]  = '{"sub_equal",   4'b0110, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0};
        vecs[2]  = '{"add_ovf",     4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
        vecs[3]  = '{"sub_ovf",     4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
        vecs[4]  = '{"add_carry",   4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
        vecs[5]  = '{"and",         4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
        vecs[6]  = '{"or",          4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0};
        vecs[7]  = '{"nor",         4'b1100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0};
        vecs[8]  = '{"undef_0011",  4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00000000, 1'b1, 1'b0};
        vecs[9]  = '{"slt_neg1_1",  4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
        vecs[10] = '{"slt_min_max", 4'b0111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0};
        vecs[11] = '{"slt_max_min", 4'b0111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0};
        vecs[12] = '{"slt_equal",   4'b0111, 32'h00001234, 32'h00001234, 32'h00000000, 1'b1, 1'b0};
        vecs[13] = '{"undef_1111",  4'b1111, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
        vecs[14] = '{"sub_ovf_pos", 4'b0110, 32'h00000001, 32'h80000000, 32'h80000001, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; aluOp = 4'b0000; data1 = 32'd0; data2 = 32'd0;

        // Reset held for two cycles
        step(1'b1, 1'b0, 4'b0000, 32'd0, 32'd0);
        step(1'b1, 1'b0, 4'b0000, 32'd0, 32'd0);
        check_outputs("reset");

        // Reset takes priority over a valid operation
        step(1'b1, 1'b1, 4'b0001, 32'hFFFF0000, 32'h0000FFFF);
        check("rst_prio.result", {32'd0, result}, 64'd0);
        check("rst_prio.valid",  {63'd0, out_valid}, 64'd0);

        // First operation after reset deassertion
        step(1'b0, 1'b1, 4'b0010, 32'h00000010, 32'h00000020);
        check("first_op.result", {32'd0, result}, 64'h30);
        check("first_op.valid",  {63'd0, out_valid}, 64'd1);

        // Directed table, each vector against its hand-computed value
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            check({vecs[i].name, ".result"},   {32'd0, result},   {32'd0, vecs[i].res});
            check({vecs[i].name, ".zero"},     {63'd0, zero},     {63'd0, vecs[i].z});
            check({vecs[i].name, ".overflow"}, {63'd0, overflow}, {63'd0, vecs[i].ov});
            check({vecs[i].name, ".valid"},    {63'd0, out_valid}, 64'd1);
        end

        // Streaming: three back-to-back ops, then idle hold, then reset mid-stream
        step(1'b0, 1'b1, 4'b0010, 32'h00000001, 32'h00000002);
        check("stream0.result", {32'd0, result}, 64'h3);
        check("stream0.valid",  {63'd0, out_valid}, 64'd1);
        step(1'b0, 1'b1, 4'b0110, 32'h00000010, 32'h00000001);
        check("stream1.result", {32'd0, result}, 64'hF);
        check("stream1.valid",  {63'd0, out_valid}, 64'd1);
        step(1'b0, 1'b1, 4'b0001, 32'h0000A000, 32'h00000005);
        check("stream2.result", {32'd0, result}, 64'hA005);
        check("stream2.valid",  {63'd0, out_valid}, 64'd1);
        step(1'b0, 1'b0, 4'b0010, 32'h11111111, 32'h22222222);
        check("hold.result", {32'd0, result}, 64'hA005);
        check("hold.zero",   {63'd0, zero}, 64'd0);
        check("hold.valid",  {63'd0, out_valid}, 64'd0);
        step(1'b0, 1'b1, 4'b0010, 32'h7FFFFFFF, 32'h7FFFFFFF);
        check("pre_rst.overflow", {63'd0, overflow}, 64'd1);
        step(1'b1, 1'b1, 4'b0010, 32'h00000001, 32'h00000001);
        check_outputs("mid_rst");
        check("mid_rst.result", {32'd0, result}, 64'd0);

        // Randomized operations against the reference model
        op_list = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0010, 4'b0110};
        for (int n = 0; n < 300; n++) begin
            logic [31:0] ra, rb;
            rop = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : op_list[$urandom_range(0, 7)];
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = ra;
            if ($urandom_range(0, 7) == 0) ra = {ra[31], 31'h7FFFFFFF};
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), rop, ra, rb);
            check_outputs("random");
        end

        in_valid = 1'b0;
        rst = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
